// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared encodings for the data-memory arbiter.
// It holds the sequencer states, the grant owner codes and the
// starvation-counter width helper.
package dmem_arb_pkg;

  // Access sequencer states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Grant owner
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  // Starvation counter width for the default STARVE_MAX of 4
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_CNT_W   = $clog2(STARVE_MAX_DEF + 1);

  // Width needed to count 0..starve_max inclusive
  function automatic int starve_cnt_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// dmem_arb_prio: IDLE-state grant decision with a starvation guard.
// The CPU normally wins. After STARVE_MAX consecutive CPU grants made while
// the debug port waits, the debug port is forced through.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_arb_en,
  input  logic i_cpu_req,
  input  logic i_dbg_req,
  output logic o_gnt_valid,
  output logic o_gnt_sel
);

  localparam int CNT_W = starve_cnt_w(STARVE_MAX);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_dbg;

  assign w_force_dbg = i_dbg_req && (r_starve_cnt == CNT_W'(STARVE_MAX));

  // Grant decision, only meaningful while the sequencer is idle
  always_comb begin
    // NOTE: every output gets a default first so that no path through the
    // block leaves a value unassigned, which would infer a latch.
    o_gnt_valid = 1'b0;
    o_gnt_sel   = GNT_CPU;
    if (i_arb_en) begin
      if (w_force_dbg) begin
        o_gnt_valid = 1'b1;
        o_gnt_sel   = GNT_DBG;
      end else if (i_cpu_req) begin
        o_gnt_valid = 1'b1;
        o_gnt_sel   = GNT_CPU;
      end else if (i_dbg_req) begin
        o_gnt_valid = 1'b1;
        o_gnt_sel   = GNT_DBG;
      end
    end
  end

  // Count CPU grants that bypass a waiting debug request; clear on a debug grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (o_gnt_valid) begin
      if (o_gnt_sel == GNT_DBG) begin
        r_starve_cnt <= '0;
      end else if (i_dbg_req && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between the pipeline
// Mem stage (CPU) and a debug/loader port (DBG). Each access runs
// IDLE -> BUSY (MEM_LAT cycles) -> DONE -> IDLE. The pipeline is stalled
// while a CPU access is pending.
// Optional macro DMEM_ARB_PERF_EN adds stall-cycle and debug-grant counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [15:0]       perf_dbg_grants
`endif
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [1:0]        r_state;
  logic              r_grant;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic w_gnt_valid;
  logic w_gnt_sel;
  logic w_busy;
  logic w_done;

  dmem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk         (clk),
    .reset       (reset),
    .i_arb_en    (r_state == IDLE),
    .i_cpu_req   (cpu_req),
    .i_dbg_req   (dbg_req),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_sel   (w_gnt_sel)
  );

  assign w_busy = (r_state == BUSY);
  assign w_done = (r_state == DONE);

  // Memory strobes are decoded from state so an async reset drops them at once
  assign mem_en    = w_busy;
  assign mem_we    = w_busy & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign dbg_ack   = w_done && (r_grant == GNT_DBG);
  assign cpu_stall = cpu_req && !(w_done && (r_grant == GNT_CPU));

  // Access sequencer: latch the winner, count out the memory latency, complete
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_grant     <= GNT_CPU;
      r_lat_cnt   <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // here sees the pre-edge values of the others, independent of order.
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_grant   <= w_gnt_sel;
            r_we      <= (w_gnt_sel == GNT_DBG) ? dbg_we    : cpu_we;
            r_addr    <= (w_gnt_sel == GNT_DBG) ? dbg_addr  : cpu_addr;
            r_wdata   <= (w_gnt_sel == GNT_DBG) ? dbg_wdata : cpu_wdata;
            r_lat_cnt <= LAT_W'(MEM_LAT - 1);
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          if (r_lat_cnt == '0) begin
            if (r_grant == GNT_DBG) r_dbg_rdata <= mem_rdata;
            else                    r_cpu_rdata <= mem_rdata;
            r_state <= DONE;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Free-running wrap-around counters of stall cycles and debug grants
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt  <= '0;
      perf_dbg_grants <= '0;
    end else begin
      if (cpu_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (w_gnt_valid && (w_gnt_sel == GNT_DBG))
        perf_dbg_grants <= perf_dbg_grants + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with MEM_LAT = 2 and
// STARVE_MAX = 4, backed by a small behavioural memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_dbg_grants;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (2),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_ack   (dbg_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_dbg_grants (perf_dbg_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on each strobed cycle
  logic [31:0] mem [0:255];
  logic        preload;
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (preload)               mem[5] <= 32'hDEADBEEF;
    else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One CPU access; counts stalled, strobed and write cycles until completion
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int stall_cyc, output int en_cyc, output int we_cyc,
                            output logic [31:0] rdata, output logic timed_out);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    stall_cyc = 0; en_cyc = 0; we_cyc = 0; rdata = '0; timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        timed_out = 1'b0;
        break;
      end
      stall_cyc++;
      if (mem_en) en_cyc++;
      if (mem_we) we_cyc++;
      step();
    end
    cpu_req = 1'b0;
    step();
  endtask

  // One DBG access; reports cycles before ack, any CPU stall, and ack width
  task automatic dbg_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int ack_lat, output logic stall_seen,
                            output logic ack_after, output logic [31:0] rdata,
                            output logic timed_out);
    dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    ack_lat = 0; stall_seen = 1'b0; rdata = '0; timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (cpu_stall) stall_seen = 1'b1;
      if (dbg_ack) begin
        rdata = dbg_rdata;
        timed_out = 1'b0;
        break;
      end
      ack_lat++;
      step();
    end
    dbg_req = 1'b0;
    step();
    ack_after = dbg_ack;
  endtask

  initial begin
    int          stall_c, en_c, we_c, lat, n_done;
    logic        to, st_seen, ack_aft;
    logic [31:0] rd;
    logic [9:0]  gnt_bits;

    reset = 1'b0; preload = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    step(); step();

    // Reset state
    check("rst_mem_en",    mem_en,    0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_dbg_ack",   dbg_ack,   0);
    check("rst_stall_lo",  cpu_stall, 0);
    cpu_req = 1'b1; #1;
    check("rst_stall_follows_req", cpu_stall, 1);
    cpu_req = 1'b0; #1;
    step();
    reset = 1'b1; preload = 1'b0;
    step();

    // CPU load of addr 5, issued twice
    for (int k = 0; k < 2; k++) begin
      cpu_access(1'b0, 32'd5, 32'd0, stall_c, en_c, we_c, rd, to);
      check("ld5_timeout", to, 0);
      check("ld5_stall_cycles", stall_c, 3);
      check("ld5_mem_en_cycles", en_c, 2);
      check("ld5_rdata", rd, 32'hDEADBEEF);
    end
`ifdef DMEM_ARB_PERF_EN
    check("perf_stall_cnt", perf_stall_cnt, 6);
    check("perf_dbg_grants", {16'd0, perf_dbg_grants}, 0);
`endif

    // CPU store then load of addr 8
    cpu_access(1'b1, 32'd8, 32'h1234, stall_c, en_c, we_c, rd, to);
    check("st8_timeout", to, 0);
    check("st8_stall_cycles", stall_c, 3);
    check("st8_mem_we_cycles", we_c, 2);
    cpu_access(1'b0, 32'd8, 32'd0, stall_c, en_c, we_c, rd, to);
    check("ld8_timeout", to, 0);
    check("ld8_mem_we_cycles", we_c, 0);
    check("ld8_rdata", rd, 32'h00001234);

    // DBG write then read of addr 3, CPU idle
    dbg_access(1'b1, 32'd3, 32'hA5A5A5A5, lat, st_seen, ack_aft, rd, to);
    check("dbgwr_timeout", to, 0);
    check("dbgwr_ack_latency", lat, 3);
    check("dbgwr_ack_one_cycle", ack_aft, 0);
    check("dbgwr_no_cpu_stall", st_seen, 0);
    dbg_access(1'b0, 32'd3, 32'd0, lat, st_seen, ack_aft, rd, to);
    check("dbgrd_timeout", to, 0);
    check("dbgrd_rdata", rd, 32'hA5A5A5A5);
    check("dbgrd_no_cpu_stall", st_seen, 0);

    // Both requesters held: expect C C C C D C C C C D
    cpu_we = 1'b0; cpu_addr = 32'd5;
    dbg_we = 1'b0; dbg_addr = 32'd3;
    cpu_req = 1'b1; dbg_req = 1'b1;
    gnt_bits = '0; n_done = 0;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (!cpu_stall) begin
        gnt_bits = {gnt_bits[8:0], 1'b0};
        n_done++;
      end else if (dbg_ack) begin
        gnt_bits = {gnt_bits[8:0], 1'b1};
        n_done++;
      end
      if (n_done == 10) break;
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("starve_completions", n_done, 10);
    check("starve_grant_seq", {22'd0, gnt_bits}, {22'd0, 10'b0000100001});
    check("starve_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("starve_dbg_rdata", dbg_rdata, 32'hA5A5A5A5);
    step();

    // Reset asserted in the middle of a CPU store
    cpu_we = 1'b1; cpu_addr = 32'd9; cpu_wdata = 32'h55; cpu_req = 1'b1;
    step();
    check("midrst_busy_en", mem_en, 1);
    check("midrst_busy_we", mem_we, 1);
    reset = 1'b0; #1;
    check("midrst_async_en", mem_en, 0);
    check("midrst_async_we", mem_we, 0);
    check("midrst_stall_in_reset", cpu_stall, 1);
    cpu_req = 1'b0;
    step();
    check("midrst_cpu_rdata_cleared", cpu_rdata, 0);
    reset = 1'b1;
    step();
    check("midrst_idle_after_release", mem_en, 0);
    cpu_access(1'b0, 32'd5, 32'd0, stall_c, en_c, we_c, rd, to);
    check("reissue_timeout", to, 0);
    check("reissue_stall_cycles", stall_c, 3);
    check("reissue_rdata", rd, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit in case a bounded loop is ever bypassed
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
